// File: rtl/bpred_gshare.sv
// rtl/bpred_gshare.sv - gshare direction predictor with direct-mapped BTB and branch statistics
module bpred_gshare #(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_BITS    = 6,
    localparam int IDX_W      = $clog2(BHT_ENTRIES),
    localparam int BTB_W      = $clog2(BTB_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_f,
    output logic              pred_taken_f,
    output logic [31:0]       pred_pc_f,
    output logic [IDX_W-1:0]  pred_idx_f,
    input  logic              upd_valid,
    input  logic              upd_is_jump,
    input  logic [31:0]       upd_pc,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_mispredict,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);
    localparam int TAG_W = 30 - BTB_W;

    logic [1:0]             pht [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_ENTRIES-1:0] btb_jump;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [GHR_BITS-1:0]    ghr;

    logic [BTB_W-1:0] f_set;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [BTB_W-1:0] u_set;
    logic             cond_upd;
    logic             btb_wr;
    logic             unused_pc_lsb;

    // Byte offset of the update PC carries no information for indexing.
    assign unused_pc_lsb = ^upd_pc[1:0];

    assign f_set        = pc_f[BTB_W+1:2];
    assign f_tag        = pc_f[31:BTB_W+2];
    assign pred_idx_f   = pc_f[IDX_W+1:2] ^ IDX_W'(ghr);
    assign f_hit        = btb_valid[f_set] && (btb_tag[f_set] == f_tag);
    assign pred_taken_f = f_hit && (btb_jump[f_set] || pht[pred_idx_f][1]);
    assign pred_pc_f    = pred_taken_f ? btb_target[f_set] : pc_f + 32'd4;

    assign u_set    = upd_pc[BTB_W+1:2];
    assign cond_upd = upd_valid && !upd_is_jump;
    assign btb_wr   = upd_valid && upd_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
            ghr <= '0;
        end else if (cond_upd) begin
            if (upd_taken && pht[upd_idx] != 2'b11) begin
                pht[upd_idx] <= pht[upd_idx] + 2'b01;
            end else if (!upd_taken && pht[upd_idx] != 2'b00) begin
                pht[upd_idx] <= pht[upd_idx] - 2'b01;
            end
            ghr <= {ghr[GHR_BITS-2:0], upd_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
            btb_jump  <= '0;
        end else if (btb_wr) begin
            btb_valid[u_set] <= 1'b1;
            btb_jump[u_set]  <= upd_is_jump;
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[u_set]    <= upd_pc[31:BTB_W+2];
            btb_target[u_set] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (upd_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_bpred_gshare.sv
// tb/tb_bpred_gshare.sv - scoreboard bench for bpred_gshare against a behavioural table model
module tb_bpred_gshare;
    localparam int IDX_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pc_f;
    logic              pred_taken_f;
    logic [31:0]       pred_pc_f;
    logic [IDX_W-1:0]  pred_idx_f;
    logic              upd_valid;
    logic              upd_is_jump;
    logic [31:0]       upd_pc;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispredict;
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;

    bpred_gshare dut (
        .clk              (clk),
        .rst              (rst),
        .pc_f             (pc_f),
        .pred_taken_f     (pred_taken_f),
        .pred_pc_f        (pred_pc_f),
        .pred_idx_f       (pred_idx_f),
        .upd_valid        (upd_valid),
        .upd_is_jump      (upd_is_jump),
        .upd_pc           (upd_pc),
        .upd_idx          (upd_idx),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic [31:0] npc;
        logic [5:0]  idx;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model of predictor state
    logic [1:0]  m_pht [64];
    logic        m_valid [32];
    logic        m_jmp [32];
    logic [24:0] m_tag [32];
    logic [31:0] m_tgt [32];
    logic [5:0]  m_ghr;
    logic [31:0] m_br, m_mp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        m_ghr = '0;
        m_br  = '0;
        m_mp  = '0;
    endtask

    function automatic logic [5:0] m_idx(input logic [31:0] pc);
        return pc[7:2] ^ m_ghr;
    endfunction

    function automatic exp_t m_pred(input logic [31:0] pc);
        exp_t e;
        int   s;
        logic hit;
        s       = int'(pc[6:2]);
        e.idx   = m_idx(pc);
        hit     = m_valid[s] && (m_tag[s] == pc[31:7]);
        e.taken = hit && (m_jmp[s] || (m_pht[e.idx] >= 2'b10));
        e.npc   = e.taken ? m_tgt[s] : pc + 32'd4;
        e.br    = m_br;
        e.mp    = m_mp;
        return e;
    endfunction

    task automatic m_update(input logic j, input logic [31:0] upc, input logic [5:0] uidx,
                            input logic t, input logic [31:0] tgt, input logic mp);
        int s;
        s = int'(upc[6:2]);
        if (!j) begin
            if (t) m_pht[uidx] = (m_pht[uidx] == 2'b11) ? 2'b11 : m_pht[uidx] + 2'b01;
            else   m_pht[uidx] = (m_pht[uidx] == 2'b00) ? 2'b00 : m_pht[uidx] - 2'b01;
            m_ghr = {m_ghr[4:0], t};
        end
        if (t) begin
            m_valid[s] = 1'b1;
            m_jmp[s]   = j;
            m_tag[s]   = upc[31:7];
            m_tgt[s]   = tgt;
        end
        m_br = m_br + 32'd1;
        if (mp) m_mp = m_mp + 32'd1;
    endtask

    // One cycle: drive fetch PC and optional update, compare outputs before the edge.
    task automatic step(input logic [31:0] pc, input logic v, input logic j,
                        input logic [31:0] upc, input logic [5:0] uidx, input logic t,
                        input logic [31:0] tgt, input logic mp);
        exp_t e;
        pc_f           = pc;
        upd_valid      = v;
        upd_is_jump    = j;
        upd_pc         = upc;
        upd_idx        = uidx;
        upd_taken      = t;
        upd_target     = tgt;
        upd_mispredict = mp;
        sb.push_back(m_pred(pc));
        @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("pred_taken", 64'(pred_taken_f), 64'(e.taken));
            check("pred_pc", 64'(pred_pc_f), 64'(e.npc));
            check("pred_idx", 64'(pred_idx_f), 64'(e.idx));
            check("stat_branches", 64'(stat_branches), 64'(e.br));
            check("stat_mispredicts", 64'(stat_mispredicts), 64'(e.mp));
        end
        @(posedge clk);
        if (v) m_update(j, upc, uidx, t, tgt, mp);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        step(pc, 1'b0, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0);
    endtask

    logic [5:0] ui;

    initial begin
        rst = 1'b1;
        pc_f = 32'h100;
        upd_valid = 1'b0; upd_is_jump = 1'b0; upd_pc = '0; upd_idx = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
        m_reset();
        @(negedge clk);
        check("reset_taken", 64'(pred_taken_f), 64'd0);
        check("reset_pc", 64'(pred_pc_f), 64'h104);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state observed at 0x100
        idle(32'h100);

        // Three taken conditional updates at 0x100
        for (int k = 0; k < 3; k++) begin
            ui = m_idx(32'h100);
            step(32'h100, 1'b1, 1'b0, 32'h100, ui, 1'b1, 32'h80, 1'b1);
        end
        check("pht_after_three", 64'(dut.pht[ui]), 64'(m_pht[ui]));
        check("ghr_after_three", 64'(dut.ghr), 64'b000111);
        idle(32'h100);

        // Unconditional jump: BTB hit forces taken, GHR untouched
        step(32'h200, 1'b1, 1'b1, 32'h200, 6'h2A, 1'b1, 32'h400, 1'b0);
        idle(32'h200);
        check("jump_pred_pc", 64'(pred_pc_f), 64'h400);
        check("ghr_after_jump", 64'(dut.ghr), 64'b000111);

        // Saturation at one index (BTB set 1 only written by the taken ones)
        for (int k = 0; k < 6; k++)
            step(32'h104, 1'b1, 1'b0, 32'h104, 6'h1E, 1'b0, 32'h0, 1'b0);
        check("pht_sat_low", 64'(dut.pht[6'h1E]), 64'd0);
        idle(32'h104);
        for (int k = 0; k < 5; k++)
            step(32'h104, 1'b1, 1'b0, 32'h104, 6'h1E, 1'b1, 32'h500, 1'b0);
        check("pht_sat_high", 64'(dut.pht[6'h1E]), 64'd3);
        idle(32'h104);

        // Alias in BTB set 0: second tag evicts the first
        step(32'h100, 1'b1, 1'b0, 32'h180, m_idx(32'h180), 1'b1, 32'h900, 1'b1);
        idle(32'h100);
        check("alias_miss_pc", 64'(pred_pc_f), 64'h104);
        idle(32'h180);

        // Not-taken update keeps the entry; idle inputs with upd_valid=0 are ignored
        step(32'h180, 1'b1, 1'b0, 32'h180, m_idx(32'h180), 1'b0, 32'hDEAD, 1'b0);
        idle(32'h180);
        step(32'h180, 1'b0, 1'b1, 32'h180, 6'h3F, 1'b1, 32'hBEEF, 1'b1);
        for (int k = 0; k < 8; k++) idle($urandom_range(0, 255) << 2);

        // Counter wrap
        force dut.stat_branches = 32'hFFFF_FFFF;
        force dut.stat_mispredicts = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branches;
        release dut.stat_mispredicts;
        m_br = 32'hFFFF_FFFF;
        m_mp = 32'hFFFF_FFFF;
        step(32'h180, 1'b1, 1'b0, 32'h300, 6'h05, 1'b0, 32'h0, 1'b1);
        idle(32'h180);
        check("wrap_branches", 64'(stat_branches), 64'd0);

        // Reset during a live update discards it
        ui = m_idx(32'h100);
        pc_f = 32'h100; upd_valid = 1'b1; upd_is_jump = 1'b0; upd_pc = 32'h100;
        upd_idx = ui; upd_taken = 1'b1; upd_target = 32'h700; upd_mispredict = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_taken", 64'(pred_taken_f), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        idle(32'h100);
        check("midrst_pht", 64'(dut.pht[ui]), 64'd1);
        check("midrst_ghr", 64'(dut.ghr), 64'd0);
        idle(32'h100);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
